// File: rtl/alu_pkg.sv
// Shared constants and types for the 8-bit execute stage.
// Opcodes, FSM states, flag bit positions and the data width.
package alu_pkg;

    localparam int DW         = 8;
    localparam int MUL_CYCLES = 8;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_exec_if.sv
// Request and write-back bundle between the register file and
// the execute stage; master issues ops, slave is the ALU.
interface alu_exec_if;
    import alu_pkg::*;

    logic          start;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    dest;

    logic          busy;
    logic          done;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    flags;

    modport master (
        output start, op, a, b, dest,
        input  busy, done, wb_en, wb_addr, wb_data, flags
    );

    modport slave (
        input  start, op, a, b, dest,
        output busy, done, wb_en, wb_addr, wb_data, flags
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per clock.
// fin is high during the last step; prod already includes it.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            fin,
    output logic [2*DW-1:0] prod
);

    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [2:0]      cnt;
    logic            run;
    logic [2*DW-1:0] step;

    assign step = mplier[0] ? acc + mcand : acc;
    assign fin  = run && (cnt == 3'(MUL_CYCLES - 1));
    assign prod = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (go) begin
            acc    <= '0;
            mcand  <= {{DW{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 3'd1;
            if (fin)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus optional 8-cycle MUL.
// Define ALU_MUL_EN to build the multiplier; otherwise op C is illegal.
module alu_exec
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    alu_exec_if.slave bus
);

    logic [DW-1:0] a, b, res;
    logic [DW:0]   s_add, s_sub, s_inc, s_dec;
    logic          c, v, wr, legal;
    logic          busy, is_mul, sc_fire;
    logic          done_q, wb_en_q;
    logic [2:0]    addr_q;
    logic [DW-1:0] data_q;
    logic [3:0]    flg_q;

    assign a     = bus.a;
    assign b     = bus.b;
    assign s_add = {1'b0, a} + {1'b0, b};
    assign s_sub = {1'b0, a} - {1'b0, b};
    assign s_inc = {1'b0, a} + 9'd1;
    assign s_dec = {1'b0, a} - 9'd1;

    always_comb begin
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        wr    = 1'b1;
        legal = 1'b1;
        unique case (1'b1)
            bus.op == OP_ADD: begin
                res = s_add[7:0];
                c   = s_add[8];
                v   = (a[7] == b[7]) && (res[7] != a[7]);
            end
            bus.op == OP_SUB, bus.op == OP_CMP: begin
                res = s_sub[7:0];
                c   = s_sub[8];
                v   = (a[7] != b[7]) && (res[7] != a[7]);
                wr  = (bus.op == OP_SUB);
            end
            bus.op == OP_AND: res = a & b;
            bus.op == OP_OR:  res = a | b;
            bus.op == OP_XOR: res = a ^ b;
            bus.op == OP_NOT: res = ~a;
            bus.op == OP_SHL: begin
                res = {a[6:0], 1'b0};
                c   = a[7];
            end
            bus.op == OP_SHR: begin
                res = {1'b0, a[7:1]};
                c   = a[0];
            end
            bus.op == OP_MOV: res = b;
            bus.op == OP_INC: begin
                res = s_inc[7:0];
                c   = s_inc[8];
                v   = (a == 8'h7F);
            end
            bus.op == OP_DEC: begin
                res = s_dec[7:0];
                c   = s_dec[8];
                v   = (a == 8'h80);
            end
            default: begin
                wr    = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    state_t          state, state_nx;
    logic            mul_go, mul_fin;
    logic [2*DW-1:0] prod;
    logic [2:0]      dest_q;

    assign is_mul = (bus.op == OP_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (bus.start && is_mul) state_nx = ST_MUL;
            ST_MUL:  if (mul_fin) state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_MUL);
        mul_go = (state == ST_IDLE) && bus.start && is_mul;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dest_q <= '0;
        else if (mul_go)
            dest_q <= bus.dest;
    end

    alu_mul_seq u_mul (
        .clk  (clk),
        .rst  (rst),
        .go   (mul_go),
        .a    (a),
        .b    (b),
        .fin  (mul_fin),
        .prod (prod)
    );
`else
    assign busy   = 1'b0;
    assign is_mul = 1'b0;
`endif

    assign sc_fire = bus.start && !busy && !is_mul;

    // wb_addr/wb_data only move on a real write so they hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            flg_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            if (sc_fire) begin
                done_q  <= 1'b1;
                wb_en_q <= wr;
                if (wr) begin
                    addr_q <= bus.dest;
                    data_q <= res;
                end
                if (legal)
                    flg_q <= {res == 8'h00, res[7], c, v};
            end
`ifdef ALU_MUL_EN
            else if (mul_fin) begin
                done_q       <= 1'b1;
                wb_en_q      <= 1'b1;
                addr_q       <= dest_q;
                data_q       <= prod[7:0];
                flg_q[FLG_Z] <= (prod[7:0] == 8'h00);
                flg_q[FLG_N] <= prod[7];
                flg_q[FLG_C] <= |prod[15:8];
                flg_q[FLG_V] <= |prod[15:8];
            end
`endif
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_addr = addr_q;
    assign bus.wb_data = data_q;
    assign bus.flags   = flg_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec; MUL checks run only when
// ALU_MUL_EN is defined, otherwise opcode C is checked as illegal.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [2:0] exp_addr;
    logic [7:0] exp_data;

    alu_exec_if bus();

    alu_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] d;
        logic       wr;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] d);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.dest  = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.dest  = ~d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 16'(bus.busy), 16'd0);
        chk({tag, ".done"}, 16'(bus.done), 16'd0);
        chk({tag, ".wb_en"}, 16'(bus.wb_en), 16'd0);
        chk({tag, ".addr"}, 16'(bus.wb_addr), 16'd0);
        chk({tag, ".data"}, 16'(bus.wb_data), 16'd0);
        chk({tag, ".flags"}, 16'(bus.flags), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.dest  = '0;
        exp_addr  = '0;
        exp_data  = '0;

        tv.push_back('{OP_ADD, 8'h7F, 8'h01, 3'd3, 1'b1, 8'h80, 4'b0101});
        tv.push_back('{OP_SUB, 8'h05, 8'h07, 3'd2, 1'b1, 8'hFE, 4'b0110});
        tv.push_back('{OP_CMP, 8'h10, 8'h10, 3'd1, 1'b0, 8'h00, 4'b1000});
        tv.push_back('{OP_INC, 8'hFF, 8'h00, 3'd4, 1'b1, 8'h00, 4'b1010});
        tv.push_back('{OP_SHR, 8'h01, 8'h00, 3'd5, 1'b1, 8'h00, 4'b1010});
        tv.push_back('{OP_MOV, 8'h00, 8'h5A, 3'd6, 1'b1, 8'h5A, 4'b0000});
        tv.push_back('{OP_ADD, 8'hFF, 8'h01, 3'd1, 1'b1, 8'h00, 4'b1010});
        tv.push_back('{OP_SUB, 8'h80, 8'h01, 3'd7, 1'b1, 8'h7F, 4'b0001});
        tv.push_back('{OP_DEC, 8'h00, 8'h00, 3'd2, 1'b1, 8'hFF, 4'b0110});
        tv.push_back('{OP_DEC, 8'h80, 8'h00, 3'd3, 1'b1, 8'h7F, 4'b0001});
        tv.push_back('{OP_SHL, 8'h81, 8'h00, 3'd4, 1'b1, 8'h02, 4'b0010});
        tv.push_back('{OP_AND, 8'hF0, 8'h0F, 3'd5, 1'b1, 8'h00, 4'b1000});
        tv.push_back('{OP_OR,  8'h80, 8'h01, 3'd6, 1'b1, 8'h81, 4'b0100});
        tv.push_back('{OP_XOR, 8'hF0, 8'hFF, 3'd7, 1'b1, 8'h0F, 4'b0000});
        tv.push_back('{OP_NOT, 8'hFF, 8'h00, 3'd0, 1'b1, 8'h00, 4'b1000});
        tv.push_back('{4'hD,   8'h01, 8'h01, 3'd7, 1'b0, 8'h00, 4'b1000});
`ifndef ALU_MUL_EN
        tv.push_back('{OP_MUL, 8'h03, 8'h03, 3'd6, 1'b0, 8'h00, 4'b1000});
`endif
        tv.push_back('{4'hF,   8'hFF, 8'hFF, 3'd1, 1'b0, 8'h00, 4'b1000});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        issue(OP_ADD, 8'h7F, 8'h01, 3'd3);
        chk("pre.done", 16'(bus.done), 16'd1);
        chk("pre.data", 16'(bus.wb_data), 16'h80);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back: a new start is presented every cycle
        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, tv[i].d);
            if (tv[i].wr) begin
                exp_addr = tv[i].d;
                exp_data = tv[i].res;
            end
            chk($sformatf("v%0d.done", i), 16'(bus.done), 16'd1);
            chk($sformatf("v%0d.wb_en", i), 16'(bus.wb_en),
                16'(tv[i].wr));
            chk($sformatf("v%0d.addr", i), 16'(bus.wb_addr),
                16'(exp_addr));
            chk($sformatf("v%0d.data", i), 16'(bus.wb_data),
                16'(exp_data));
            chk($sformatf("v%0d.flags", i), 16'(bus.flags),
                16'(tv[i].flg));
            chk($sformatf("v%0d.busy", i), 16'(bus.busy), 16'd0);
        end

        @(posedge clk);
        #1;
        chk("idle.done", 16'(bus.done), 16'd0);
        chk("idle.wb_en", 16'(bus.wb_en), 16'd0);
        chk("idle.data", 16'(bus.wb_data), 16'(exp_data));
        chk("idle.addr", 16'(bus.wb_addr), 16'(exp_addr));

`ifdef ALU_MUL_EN
        issue(OP_MUL, 8'h0C, 8'h0B, 3'd5);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m1.busy%0d", i), 16'(bus.busy), 16'd1);
            chk($sformatf("m1.done%0d", i), 16'(bus.done), 16'd0);
            if (i == 2) begin
                bus.op    = OP_ADD;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
                bus.dest  = 3'd0;
                bus.start = 1'b1;
            end
            if (i == 3)
                bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("m1.done", 16'(bus.done), 16'd1);
        chk("m1.wb_en", 16'(bus.wb_en), 16'd1);
        chk("m1.busy", 16'(bus.busy), 16'd0);
        chk("m1.addr", 16'(bus.wb_addr), 16'd5);
        chk("m1.data", 16'(bus.wb_data), 16'h84);
        chk("m1.flags", 16'(bus.flags), 16'b0100);

        issue(OP_MUL, 8'h20, 8'h10, 3'd6);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m2.busy%0d", i), 16'(bus.busy), 16'd1);
            @(posedge clk);
            #1;
        end
        chk("m2.done", 16'(bus.done), 16'd1);
        chk("m2.addr", 16'(bus.wb_addr), 16'd6);
        chk("m2.data", 16'(bus.wb_data), 16'h00);
        chk("m2.flags", 16'(bus.flags), 16'b1011);

        issue(OP_MUL, 8'h03, 8'h03, 3'd2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("m3.busy4", 16'(bus.busy), 16'd1);
        rst = 1'b1;
        #1;
        chk("m3.rst_busy", 16'(bus.busy), 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("m3.nodone%0d", i), 16'(bus.done), 16'd0);
            chk($sformatf("m3.nobusy%0d", i), 16'(bus.busy), 16'd0);
        end

        issue(OP_ADD, 8'h01, 8'h02, 3'd1);
        chk("post.done", 16'(bus.done), 16'd1);
        chk("post.addr", 16'(bus.wb_addr), 16'd1);
        chk("post.data", 16'(bus.wb_data), 16'h03);
        chk("post.flags", 16'(bus.flags), 16'b0000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the 8-bit processor, sitting directly downstream of the register file's two read ports and upstream of its write port. It latches two operands and an opcode on `start`, computes the result (single-cycle ALU ops or an 8-cycle shift-add multiply), and presents one write-back pulse (`wb_en`/`wb_addr`/`wb_data`) that drives `reg_write`/`write_addr`/`in` directly. It also updates a registered Z/N/C/V flag set.

## Interface
- `MUL_CYCLES`, 8: iteration count of the multiplier; fixed at operand width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 4: opcode; see Operation.
- `a` in 8: operand A (register file `out1`).
- `b` in 8: operand B (register file `out2`).
- `dest` in 3: destination register index.
- `busy` out 1: a multiply is in progress; `start` is ignored.
- `done` out 1: one-cycle pulse when an op completes.
- `wb_en` out 1: one-cycle write-back strobe; drives `reg_write`.
- `wb_addr` out 3: latched `dest`.
- `wb_data` out 8: result.
- `flags` out 4: {Z,N,C,V}; registered.

## Operation
- Opcodes:
  - 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR.
  - 5 NOT ~a; 6 SHL a<<1; 7 SHR a>>1 (logical).
  - 8 MOV b; 9 INC a+1; A DEC a−1; B CMP a−b; C MUL low byte of a×b.
  - D–F illegal.
- States: IDLE, MUL.
  - IDLE + `start` + single-cycle op → stay IDLE and register result.
  - IDLE + `start` + MUL → MUL, counter=0.
  - MUL when counter=MUL_CYCLES−1 → IDLE and register result.
- Write-back:
  - `wb_en`=`done` for every op except CMP and illegal opcodes.
  - CMP and illegal opcodes pulse `done` with `wb_en`=0.
  - Illegal opcodes leave `flags` unchanged.
- Flags update in the `done` cycle only:
  - Z = (result==0); N = result[7].
  - C: carry-out for ADD/INC; borrow (a<b unsigned) for SUB/CMP; borrow (a==0) for DEC; shifted-out bit for SHL/SHR.
  - V: signed overflow for ADD/SUB/CMP/INC/DEC.
  - AND/OR/XOR/NOT/MOV clear C and V.
  - MUL: C=V=(upper product byte ≠ 0).
- Arithmetic is 9-bit internally for carry. Wrap-around is modulo 256 (0xFF+1 → 0x00, C=1).
- Operands are latched at acceptance. `a`, `b` and `dest` may change freely afterwards.
- `start` while `busy`=1 is dropped, not queued.

## Timing
- Reset:
  - Outputs `busy`, `done`, `wb_en`, `wb_addr`, `wb_data` and `flags` are all 0.
  - State IDLE; counter 0.
- Single-cycle ops:
  - `start` sampled at edge T → `done`/`wb_en`/`wb_data` valid in cycle T+1.
  - Back-to-back `start` every cycle is legal, giving one result per cycle.
- MUL:
  - Accepted at edge T → `busy`=1 for cycles T+1..T+8.
  - `done`/`wb_en` in T+9 with `busy`=0.
  - A new `start` in cycle T+9 is accepted.
- `wb_data`/`wb_addr` hold their last value when `wb_en`=0.
- `rst` mid-MUL aborts: no `done` or write-back, and state returns to IDLE immediately.

## Configuration
- `ALU_MUL_EN` defined: MUL is implemented as above.
- `ALU_MUL_EN` undefined:
  - Opcode C is treated as illegal: single-cycle `done`, `wb_en`=0, `flags` unchanged.
  - `busy` is tied 0.
  - The MUL state and multiplier hardware are removed.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (OP_ADD..OP_MUL);
  - the state enum (ST_IDLE, ST_MUL);
  - flag bit indices (FLG_Z/N/C/V);
  - the data width constant 8.
- One sub-module, `alu_mul_seq`:
  - shift-add multiplier with 16-bit accumulator, `go`/`fin` handshake and 3-bit counter;
  - instantiated only under `ALU_MUL_EN`.

## Test plan
- Reset asserted mid-stream → all outputs 0. ADD a=0x7F b=0x01 dest=3 → next cycle `wb_en`=1, `wb_addr`=3, `wb_data`=0x80, flags Z0 N1 C0 V1.
- SUB a=0x05 b=0x07 → `wb_data`=0xFE, C=1, N=1. CMP a=0x10 b=0x10 → `wb_en`=0, `done`=1, Z=1.
- Back-to-back INC 0xFF, SHR 0x01, MOV b=0x5A on consecutive cycles → 0x00 (Z1 C1), 0x00 (C1), 0x5A.
- MUL a=0x0C b=0x0B → `busy` 8 cycles, `done` at T+9, `wb_data`=0x84, C=V=0. MUL 0x20×0x10 → 0x00, C=V=1. `start` during `busy` is ignored.
- `rst` pulsed at 4th busy cycle of MUL → no `done`, `busy`=0. Next ADD completes normally.
- Built without `ALU_MUL_EN`: MUL a=3 b=3 → `done` at T+1, `wb_en`=0, `flags` unchanged, `busy` never 1.
